// File: rtl/modulo_medidor_periodo_if.sv
// Bundle of the measurement request, slow input and result signals.
// master: drives start/sig_in and reads results. slave: the measuring block.
// period/high_time are CNT_W wide; CNT_W must match the attached measurer.
interface modulo_medidor_periodo_if #(
    parameter int CNT_W = 20
) ();
    logic             start;
    logic             sig_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             overflow;

    modport master (
        output start, sig_in,
        input  busy, done, period, high_time, overflow
    );

    modport slave (
        input  start, sig_in,
        output busy, done, period, high_time, overflow
    );
endinterface

// File: rtl/modulo_medidor_periodo.sv
// Measures period and high time of a slow square wave in clk cycles.
// Latency: sig_in edge to event is SYNC_STAGES+1 cycles; done pulses one cycle after the
// closing rise or on counter saturation. No backpressure: start is honoured only when idle.
// Ports: clk, clr (sync, active-high); bus.start/sig_in in; bus.busy/done/period/high_time/overflow out.
module modulo_medidor_periodo #(
    parameter int CNT_W       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        clr,
    modulo_medidor_periodo_if.slave     bus
);

    localparam int SUP_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SUP_W-1:0] SUP_INIT = SUP_W'(SYNC_STAGES + 1);
    localparam logic [SUP_W-1:0] SUP_ONE  = {{(SUP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input path: synchronizer, history register, edge events
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [SUP_W-1:0]       sup_q;
    logic                   s;
    logic                   ev_ok;
    logic                   rise_evt;
    logic                   fall_evt;

    assign s        = sync_q[SYNC_STAGES-1];
    // Events stay masked while the synchronizer refills after clr, otherwise a
    // high sig_in would look like a fresh rising edge.
    assign ev_ok    = (sup_q == '0);
    assign rise_evt = ev_ok &  s & ~hist_q;
    assign fall_evt = ev_ok & ~s &  hist_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            sup_q  <= SUP_INIT;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            hist_q <= s;
            if (sup_q != '0) begin
                sup_q <= sup_q - SUP_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM with registered results
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             near_max;
    logic [CNT_W-1:0] hcap_q;
    logic             hflag_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             overflow_q;

    // Saturating increment; the FSM leaves on the cycle the count would reach all-ones.
    assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    assign near_max = (cnt_q >= CNT_PRE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hcap_q      <= '0;
            hflag_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= ARM;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        overflow_q <= 1'b0;
                    end
                end

                ARM: begin
                    if (rise_evt) begin
                        // The opening rise counts as cycle 1 of the period.
                        cnt_q   <= CNT_ONE;
                        hflag_q <= 1'b0;
                        state_q <= MEASURE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (near_max) begin
                            period_q    <= CNT_MAX;
                            high_time_q <= CNT_MAX;
                            overflow_q  <= 1'b1;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= DONE;
                        end
                    end
                end

                MEASURE: begin
                    if (rise_evt) begin
                        period_q    <= cnt_q;
                        high_time_q <= hflag_q ? hcap_q : '0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        // Only the first fall after the opening rise defines high time.
                        if (fall_evt && !hflag_q) begin
                            hcap_q  <= cnt_q;
                            hflag_q <= 1'b1;
                        end
                        if (near_max) begin
                            period_q <= CNT_MAX;
                            if (hflag_q) begin
                                high_time_q <= hcap_q;
                            end else if (fall_evt) begin
                                high_time_q <= cnt_q;
                            end else begin
                                high_time_q <= CNT_MAX;
                            end
                            overflow_q <= 1'b1;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= DONE;
                        end
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.period    = period_q;
    assign bus.high_time = high_time_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: doc/modulo_medidor_periodo.md
Name: modulo_medidor_periodo

Overview:
- Measures the period and high time of a slow square wave, in counts of the fast system clock.
- Typical source: a divided-clock output, or any external slow signal.
- Acts as the receiving end of the frequency-divider chain: it recovers the division ratio from the slow waveform.
- Used for self-test of the divider chain and for measuring external signal frequency.

Parameters:
- CNT_W, 20, width of the cycle counter and of the period/high_time results; maximum measurable value is 2^CNT_W-1.
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on sig_in (legal values 2..3).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- clr  input  1  synchronous reset, active-high.
- start  input  1  single-cycle request to begin one measurement; honoured only in IDLE.
- sig_in  input  1  asynchronous slow signal being measured.
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
- done  output  1  single-cycle pulse when a measurement completes, including overflow completion.
- period  output  CNT_W  clk cycles between two consecutive rising edges of sig_in; held until the next done.
- high_time  output  CNT_W  clk cycles from the measured rising edge to the following falling edge; held until the next done.
- overflow  output  1  set with done when the counter saturated; cleared on the next accepted start.

Behaviour:
- Reset:
  - clr high at a rising clk edge sets busy, done, period, high_time and overflow to 0.
  - It also zeroes the synchronizer, the edge history register and the counter, and puts the FSM in IDLE.
  - clr has priority over every other input, including mid-measurement; a partial result is discarded and done does not pulse.
- Input path:
  - sig_in passes through SYNC_STAGES flip-flops to give s, then one history register p.
  - rise_evt = s & ~p; fall_evt = ~s & p.
  - Edge-to-event latency is SYNC_STAGES+1 clk cycles.
  - Events are suppressed for SYNC_STAGES+1 cycles after clr deasserts, so no false edge is produced while the stages refill.
- Counter cnt (CNT_W bits) saturates at all-ones and never wraps.
- FSM states and transitions:
  - IDLE: start=1 moves to ARM with cnt<=0, busy<=1, overflow<=0. Events are ignored, including a rise_evt in the same cycle as start.
  - ARM: waits for the first rise_evt.
    - On rise_evt: cnt<=1, high_time capture flag cleared, go to MEASURE.
    - Otherwise cnt increments. If cnt reaches all-ones: period<=all-ones, high_time<=all-ones, overflow<=1, go to DONE.
  - MEASURE: cnt increments every cycle with no rise_evt.
    - First fall_evt: high_time register<=cnt and flag set. Later falls are ignored.
    - rise_evt: period<=cnt, so period equals the cycle distance between the two rise events. If no fall was captured, high_time<=0. Go to DONE.
    - cnt reaches all-ones before the second rise: period<=all-ones, overflow<=1, high_time<=captured value or all-ones if none. Go to DONE.
  - DONE: done=1 and busy<=0 for exactly one cycle, then IDLE.
- Result registers update only on the transition into DONE.
- start asserted in ARM, MEASURE or DONE is ignored; there is no queuing.
- Rise and fall events are mutually exclusive in a single cycle by construction.

Test Plan:
- Clean 50% square wave, sig_in period 20 clk cycles (10 high / 10 low); pulse start -> within 45 cycles: done pulses once, period=20, high_time=10, overflow=0, busy falls in the same cycle done rises.
- Duty cycle 3 high / 7 low; start -> period=10, high_time=3. Repeat start immediately after done -> identical result, done pulses once per start.
- CNT_W=4, sig_in held low, start -> exactly 15 cycles after entering ARM: done=1, overflow=1, period=15, high_time=15. Next start clears overflow in the following cycle.
- CNT_W=4, sig_in rises once then stays high -> done with overflow=1, period=15, high_time=15. Same with one fall after 5 cycles and no second rise -> high_time=5.
- start pulsed while busy in MEASURE, during a 20-cycle-period wave -> ignored: a single done, period=20.
- clr asserted during MEASURE for one cycle -> next cycle all outputs are 0, state is IDLE, no done pulse. A fresh start then yields a correct period=20 with no spurious edge from synchronizer refill.
